// File: rtl/cpu_pkg.sv
// Shared definitions for the register bank: default widths, the hardwired
// zero register index and the bank state encoding.
package cpu_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 64;
   localparam int DEFAULT_ADDRESS_WIDTH = 5;
   localparam int ZERO_REGISTER_INDEX   = (2 ** DEFAULT_ADDRESS_WIDTH) - 1;

   typedef enum logic {
      CLEAR,
      READY
   } bank_state_t;

endpackage

// File: rtl/register_bank_read_port.sv
// One asynchronous read port: selects between the hardwired zero register,
// same-cycle write forwarding and the stored register value.
module register_bank_read_port
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int ZERO_REGISTER = 1,
   parameter int BYPASS        = 1
) (
   input  logic                     ready,
   input  logic [ADDRESS_WIDTH-1:0] read_address,
   input  logic                     write_1,
   input  logic [ADDRESS_WIDTH-1:0] write_address_1,
   input  logic [DATA_WIDTH-1:0]    write_data_1,
   input  logic                     write_2,
   input  logic [ADDRESS_WIDTH-1:0] write_address_2,
   input  logic [DATA_WIDTH-1:0]    write_data_2,
   input  logic [DATA_WIDTH-1:0]    stored_data,
   output logic [DATA_WIDTH-1:0]    read_data
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = '1;

   // Port 2 (load writeback) is younger than port 1 in the pipeline, so it
   // takes precedence when both forward to the same address.
   always_comb begin
      read_data = '0;
      if (!ready) begin
         read_data = '0;
      end else if (ZERO_REGISTER != 0 && read_address == LAST_INDEX) begin
         read_data = '0;
      end else if (BYPASS != 0 && write_2 && write_address_2 == read_address) begin
         read_data = write_data_2;
      end else if (BYPASS != 0 && write_1 && write_address_1 == read_address) begin
         read_data = write_data_1;
      end else begin
         read_data = stored_data;
      end
   end

endmodule

// File: rtl/register_bank_multiport.sv
// Two-write, two-read register bank with a post-reset clear sweep, an
// optional hardwired zero register and optional write-to-read forwarding.
module register_bank_multiport
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
   parameter int ZERO_REGISTER  = 1,
   parameter int BYPASS         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write_1,
   input  logic [ADDRESS_WIDTH-1:0] write_address_1,
   input  logic [DATA_WIDTH-1:0]    write_data_1,
   input  logic                     write_2,
   input  logic [ADDRESS_WIDTH-1:0] write_address_2,
   input  logic [DATA_WIDTH-1:0]    write_data_2,
   input  logic [ADDRESS_WIDTH-1:0] input_address_1,
   input  logic [ADDRESS_WIDTH-1:0] input_address_2,
   output logic [DATA_WIDTH-1:0]    output_data_1,
   output logic [DATA_WIDTH-1:0]    output_data_2,
   output logic                     ready,
   output logic                     write_collision
);

   localparam int                       DEPTH      = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = '1;

   logic [DATA_WIDTH-1:0]    registers [DEPTH];
   bank_state_t              state;
   bank_state_t              next_state;
   logic [ADDRESS_WIDTH-1:0] clear_index;
   logic                     accept_1;
   logic                     accept_2;
   logic [DATA_WIDTH-1:0]    stored_1;
   logic [DATA_WIDTH-1:0]    stored_2;

   // Writes to the zero register vanish entirely, including for collision detection.
   assign accept_1 = ready && write_1 &&
                     !(ZERO_REGISTER != 0 && write_address_1 == LAST_INDEX);
   assign accept_2 = ready && write_2 &&
                     !(ZERO_REGISTER != 0 && write_address_2 == LAST_INDEX);

   always_comb begin
      next_state = state;
      case (state)
         CLEAR: begin
            if (CLEAR_ON_RESET == 0 || clear_index == LAST_INDEX) begin
               next_state = READY;
            end
         end
         READY:   next_state = READY;
         default: next_state = CLEAR;
      endcase
   end

   // ready trails the READY state by one cycle; the index saturates so the
   // sweep can never restart on its own.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= CLEAR;
         clear_index     <= '0;
         ready           <= 1'b0;
         write_collision <= 1'b0;
      end else begin
         state           <= next_state;
         ready           <= (state == READY);
         write_collision <= accept_1 && accept_2 &&
                            (write_address_1 == write_address_2);
         if (state == CLEAR && clear_index != LAST_INDEX) begin
            clear_index <= clear_index + 1'b1;
         end
      end
   end

   // Port 2 is assigned last so it wins a same-address write.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == CLEAR && CLEAR_ON_RESET != 0) begin
            registers[clear_index] <= '0;
         end
         if (accept_1) begin
            registers[write_address_1] <= write_data_1;
         end
         if (accept_2) begin
            registers[write_address_2] <= write_data_2;
         end
      end
   end

   assign stored_1 = registers[input_address_1];
   assign stored_2 = registers[input_address_2];

   register_bank_read_port #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .ZERO_REGISTER (ZERO_REGISTER),
      .BYPASS        (BYPASS)
   ) read_port_a (
      .ready           (ready),
      .read_address    (input_address_1),
      .write_1         (write_1),
      .write_address_1 (write_address_1),
      .write_data_1    (write_data_1),
      .write_2         (write_2),
      .write_address_2 (write_address_2),
      .write_data_2    (write_data_2),
      .stored_data     (stored_1),
      .read_data       (output_data_1)
   );

   register_bank_read_port #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .ZERO_REGISTER (ZERO_REGISTER),
      .BYPASS        (BYPASS)
   ) read_port_b (
      .ready           (ready),
      .read_address    (input_address_2),
      .write_1         (write_1),
      .write_address_1 (write_address_1),
      .write_data_1    (write_data_1),
      .write_2         (write_2),
      .write_address_2 (write_address_2),
      .write_data_2    (write_data_2),
      .stored_data     (stored_2),
      .read_data       (output_data_2)
   );

endmodule

// File: tb/tb_register_bank_multiport.sv
// Bench for register_bank_multiport: a forwarding instance and a BYPASS=0
// instance share all inputs and are checked against a reference array.
module tb_register_bank_multiport;
   import cpu_pkg::*;

   localparam int DW    = 64;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int LAST  = ZERO_REGISTER_INDEX;

   logic          clock = 1'b0;
   logic          reset;
   logic          write_1;
   logic [AW-1:0] write_address_1;
   logic [DW-1:0] write_data_1;
   logic          write_2;
   logic [AW-1:0] write_address_2;
   logic [DW-1:0] write_data_2;
   logic [AW-1:0] input_address_1;
   logic [AW-1:0] input_address_2;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic          ready;
   logic          write_collision;
   logic [DW-1:0] nb_out_a;
   logic [DW-1:0] nb_out_b;
   logic          nb_ready;
   logic          nb_write_collision;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] expected_q [$];
   logic          collision_q [$];
   int            compared   = 0;
   int            mismatched = 0;

   always #5 clock = ~clock;

   register_bank_multiport dut (
      .clock           (clock),
      .reset           (reset),
      .write_1         (write_1),
      .write_address_1 (write_address_1),
      .write_data_1    (write_data_1),
      .write_2         (write_2),
      .write_address_2 (write_address_2),
      .write_data_2    (write_data_2),
      .input_address_1 (input_address_1),
      .input_address_2 (input_address_2),
      .output_data_1   (out_a),
      .output_data_2   (out_b),
      .ready           (ready),
      .write_collision (write_collision)
   );

   register_bank_multiport #(.BYPASS(0)) dut_no_bypass (
      .clock           (clock),
      .reset           (reset),
      .write_1         (write_1),
      .write_address_1 (write_address_1),
      .write_data_1    (write_data_1),
      .write_2         (write_2),
      .write_address_2 (write_address_2),
      .write_data_2    (write_data_2),
      .input_address_1 (input_address_1),
      .input_address_2 (input_address_2),
      .output_data_1   (nb_out_a),
      .output_data_2   (nb_out_b),
      .ready           (nb_ready),
      .write_collision (nb_write_collision)
   );

   // Every task starts and ends 1 ns after a rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      write_1 = 1'b0;
      write_2 = 1'b0;
   endtask

   task automatic wait_for_ready(output int edges);
      edges = 0;
      while (ready !== 1'b1 && edges < 100) begin
         step();
         edges++;
      end
      if (ready !== 1'b1) edges = -1;
   endtask

   task automatic test_reset_clear();
      int edges;
      for (int i = 0; i < DEPTH; i++) begin
         write_1 = 1'b1; write_address_1 = AW'(i); write_data_1 = 64'hDEAD_BEEF;
         step();
         if (i != LAST) model[i] = 64'hDEAD_BEEF;
      end
      idle();
      input_address_1 = 5'd12; input_address_2 = 5'(LAST);
      #1;
      compared++;
      if (out_a !== model[12]) begin
         mismatched++; $display("[TB] FAIL fill_readback: got %h expected %h", out_a, model[12]);
      end
      compared++;
      if (out_b !== 64'd0) begin
         mismatched++; $display("[TB] FAIL fill_zero_register: got %h expected 0", out_b);
      end
      step();
      reset = 1'b1;
      step();
      compared++;
      if (ready !== 1'b0 || write_collision !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset_outputs: ready=%b collision=%b expected 0/0", ready, write_collision);
      end
      compared++;
      if (out_a !== 64'd0) begin
         mismatched++; $display("[TB] FAIL reset_read_forced_zero: got %h expected 0", out_a);
      end
      reset = 1'b0;
      edges = 0;
      // late writes land after their targets were swept, so only gating removes them
      while (ready !== 1'b1 && edges < 100) begin
         if (edges >= 20) begin
            write_1 = 1'b1; write_address_1 = 5'd4; write_data_1 = 64'h99;
            write_2 = 1'b1; write_address_2 = 5'd9; write_data_2 = 64'h55;
         end
         step();
         edges++;
      end
      idle();
      compared++;
      if (edges != 33) begin
         mismatched++; $display("[TB] FAIL clear_ready_latency: got %0d edges expected 33", edges);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         input_address_1 = AW'(i); input_address_2 = AW'(DEPTH - 1 - i);
         expected_q.push_back(model[i]);
         expected_q.push_back(model[DEPTH - 1 - i]);
         #1;
         compared++;
         if (out_a !== expected_q.pop_front()) begin
            mismatched++; $display("[TB] FAIL cleared_read_a[%0d]: got %h expected 0", i, out_a);
         end
         compared++;
         if (out_b !== expected_q.pop_front()) begin
            mismatched++; $display("[TB] FAIL cleared_read_b[%0d]: got %h expected 0", DEPTH - 1 - i, out_b);
         end
         step();
      end
   endtask

   task automatic test_mid_sweep();
      int edges;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      compared++;
      if (ready !== 1'b0) begin
         mismatched++; $display("[TB] FAIL mid_sweep_not_ready: got %b expected 0", ready);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_for_ready(edges);
      compared++;
      if (edges != 33) begin
         mismatched++; $display("[TB] FAIL mid_sweep_latency: got %0d edges expected 33", edges);
      end
      compared++;
      if (nb_ready !== 1'b1) begin
         mismatched++; $display("[TB] FAIL mid_sweep_nb_ready: got %b expected 1", nb_ready);
      end
   endtask

   task automatic test_bypass();
      input_address_1 = 5'd3; input_address_2 = 5'd3;
      write_1 = 1'b1; write_address_1 = 5'd3; write_data_1 = 64'h1234;
      #1;
      compared++;
      if (out_a !== 64'h1234 || out_b !== 64'h1234) begin
         mismatched++; $display("[TB] FAIL bypass_same_cycle: got %h/%h expected 1234", out_a, out_b);
      end
      compared++;
      if (nb_out_a !== model[3]) begin
         mismatched++; $display("[TB] FAIL no_bypass_old_value: got %h expected %h", nb_out_a, model[3]);
      end
      step();
      model[3] = 64'h1234;
      idle();
      #1;
      compared++;
      if (out_a !== 64'h1234) begin
         mismatched++; $display("[TB] FAIL bypass_next_cycle: got %h expected 1234", out_a);
      end
      compared++;
      if (nb_out_a !== 64'h1234) begin
         mismatched++; $display("[TB] FAIL no_bypass_next_cycle: got %h expected 1234", nb_out_a);
      end
      step();
   endtask

   task automatic test_collision();
      input_address_1 = 5'd7; input_address_2 = 5'd7;
      write_1 = 1'b1; write_address_1 = 5'd7; write_data_1 = 64'hAAAA;
      write_2 = 1'b1; write_address_2 = 5'd7; write_data_2 = 64'h5555;
      #1;
      compared++;
      if (out_a !== 64'h5555 || out_b !== 64'h5555) begin
         mismatched++; $display("[TB] FAIL bypass_port2_priority: got %h/%h expected 5555", out_a, out_b);
      end
      compared++;
      if (nb_out_a !== model[7]) begin
         mismatched++; $display("[TB] FAIL collision_old_value: got %h expected %h", nb_out_a, model[7]);
      end
      step();
      model[7] = 64'h5555;
      idle();
      compared++;
      if (write_collision !== 1'b1 || nb_write_collision !== 1'b1) begin
         mismatched++; $display("[TB] FAIL collision_pulse: got %b/%b expected 1", write_collision, nb_write_collision);
      end
      compared++;
      if (nb_out_a !== 64'h5555) begin
         mismatched++; $display("[TB] FAIL collision_port2_wins: got %h expected 5555", nb_out_a);
      end
      step();
      compared++;
      if (write_collision !== 1'b0) begin
         mismatched++; $display("[TB] FAIL collision_one_cycle: got %b expected 0", write_collision);
      end
      write_1 = 1'b1; write_address_1 = 5'(LAST); write_data_1 = 64'hAAAA;
      write_2 = 1'b1; write_address_2 = 5'(LAST); write_data_2 = 64'h5555;
      step();
      idle();
      input_address_1 = 5'(LAST); input_address_2 = 5'(LAST);
      #1;
      compared++;
      if (write_collision !== 1'b0) begin
         mismatched++; $display("[TB] FAIL zero_register_no_collision: got %b expected 0", write_collision);
      end
      compared++;
      if (nb_out_a !== 64'd0 || out_b !== 64'd0) begin
         mismatched++; $display("[TB] FAIL zero_register_after_collision: got %h/%h expected 0", nb_out_a, out_b);
      end
      step();
   endtask

   task automatic test_zero_register();
      input_address_1 = 5'(LAST); input_address_2 = 5'(LAST);
      write_2 = 1'b1; write_address_2 = 5'(LAST); write_data_2 = '1;
      #1;
      compared++;
      if (out_a !== 64'd0 || out_b !== 64'd0) begin
         mismatched++; $display("[TB] FAIL zero_register_same_cycle: got %h/%h expected 0", out_a, out_b);
      end
      step();
      idle();
      #1;
      compared++;
      if (out_a !== 64'd0 || nb_out_b !== 64'd0) begin
         mismatched++; $display("[TB] FAIL zero_register_after: got %h/%h expected 0", out_a, nb_out_b);
      end
      step();
      write_1 = 1'b1; write_address_1 = 5'd5; write_data_1 = 64'h77;
      step();
      model[5] = 64'h77;
      idle();
      input_address_1 = 5'd5; input_address_2 = 5'd5;
      #1;
      compared++;
      if (out_a !== 64'h77 || out_b !== 64'h77 || nb_out_a !== 64'h77 || nb_out_b !== 64'h77) begin
         mismatched++; $display("[TB] FAIL same_address_both_ports: got %h/%h/%h/%h expected 77", out_a, out_b, nb_out_a, nb_out_b);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      for (int n = 0; n < 40; n++) begin
         if (collision_q.size() > 0) begin
            compared++;
            if (write_collision !== collision_q.pop_front()) begin
               mismatched++; $display("[TB] FAIL b2b_collision[%0d]: got %b", n, write_collision);
            end
         end
         write_1 = 1'($urandom_range(1, 0));
         write_2 = 1'($urandom_range(1, 0));
         write_address_1 = 5'($urandom_range(31, 0));
         write_address_2 = ($urandom_range(3, 0) == 0) ? write_address_1 : 5'($urandom_range(31, 0));
         write_data_1 = {$urandom, $urandom};
         write_data_2 = {$urandom, $urandom};
         ra = ($urandom_range(1, 0) == 0) ? write_address_1 : 5'($urandom_range(31, 0));
         rb = ($urandom_range(1, 0) == 0) ? write_address_2 : 5'($urandom_range(31, 0));
         input_address_1 = ra; input_address_2 = rb;
         for (int p = 0; p < 2; p++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] e;
            a = (p == 0) ? ra : rb;
            if (a == 5'(LAST)) e = '0;
            else if (write_2 && write_address_2 == a) e = write_data_2;
            else if (write_1 && write_address_1 == a) e = write_data_1;
            else e = model[a];
            expected_q.push_back(e);
            expected_q.push_back((a == 5'(LAST)) ? '0 : model[a]);
         end
         #1;
         compared++;
         if (out_a !== expected_q.pop_front()) begin
            mismatched++; $display("[TB] FAIL b2b_read_a[%0d]: got %h", n, out_a);
         end
         compared++;
         if (nb_out_a !== expected_q.pop_front()) begin
            mismatched++; $display("[TB] FAIL b2b_nb_read_a[%0d]: got %h", n, nb_out_a);
         end
         compared++;
         if (out_b !== expected_q.pop_front()) begin
            mismatched++; $display("[TB] FAIL b2b_read_b[%0d]: got %h", n, out_b);
         end
         compared++;
         if (nb_out_b !== expected_q.pop_front()) begin
            mismatched++; $display("[TB] FAIL b2b_nb_read_b[%0d]: got %h", n, nb_out_b);
         end
         collision_q.push_back(write_1 && write_2 && write_address_1 == write_address_2 &&
                               write_address_1 != 5'(LAST));
         if (write_1 && write_address_1 != 5'(LAST)) model[write_address_1] = write_data_1;
         if (write_2 && write_address_2 != 5'(LAST)) model[write_address_2] = write_data_2;
         step();
      end
      idle();
      compared++;
      if (write_collision !== collision_q.pop_front()) begin
         mismatched++; $display("[TB] FAIL b2b_collision_final: got %b", write_collision);
      end
      step();
   endtask

   initial begin
      int edges;
      reset = 1'b1;
      idle();
      write_address_1 = '0; write_data_1 = '0;
      write_address_2 = '0; write_data_2 = '0;
      input_address_1 = '0; input_address_2 = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      step();
      step();
      reset = 1'b0;
      wait_for_ready(edges);
      compared++;
      if (edges != 33) begin
         mismatched++; $display("[TB] FAIL initial_ready_latency: got %0d edges expected 33", edges);
      end
      test_reset_clear();
      test_mid_sweep();
      test_bypass();
      test_collision();
      test_zero_register();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
